// File: rtl/uart_sched_pkg.sv
// Shared constants for the UART transmit scheduler: FSM encodings, the
// "no previous owner" marker and the default channel-header base.
package uart_sched_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_SEND_HDR  = 3'd1;
  localparam logic [2:0] ST_WAIT_HDR  = 3'd2;
  localparam logic [2:0] ST_SEND_DATA = 3'd3;
  localparam logic [2:0] ST_WAIT_DATA = 3'd4;

  // Outside the 0..7 id range, so it never matches a real requester.
  localparam logic [7:0] ID_NONE      = 8'hFF;
  localparam logic [7:0] HDR_BASE_DEF = 8'hF0;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first eligible (req & mask) bit found
// searching ptr, ptr+1, ... with explicit wrap so N need not be a power of two.
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = 3
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  input  logic [N-1:0]   mask,
  output logic [N-1:0]   onehot,
  output logic [IDW-1:0] index,
  output logic           any
);

  logic [N-1:0] elig;
  logic [N-1:0] sh;
  int           j;

  assign elig = req & mask;

  always_comb begin
    onehot = '0;
    index  = '0;
    any    = 1'b0;
    sh     = '0;
    j      = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      sh = elig >> j;
      if (!any && sh[0]) begin
        any    = 1'b1;
        onehot = {{(N-1){1'b0}}, 1'b1} << j;
        index  = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin, packet-locking scheduler sharing one 8N1 byte transmitter
// among N requesters, with an optional channel header on owner change.
module uart_tx_sched
  import uart_sched_pkg::*;
#(
  parameter int         N        = 4,
  parameter int         IDW      = 3,
  parameter int         HDR_EN   = 1,
  parameter logic [7:0] HDR_BASE = HDR_BASE_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req_valid,
  input  logic [8*N-1:0] req_data,
  input  logic [N-1:0]   req_last,
  output logic [N-1:0]   req_ready,
  output logic           tx_wr,
  output logic [7:0]     tx_data,
  input  logic           tx_busy,
  output logic [N-1:0]   grant,
  output logic           active
);

  logic [2:0]     state;
  logic [IDW-1:0] owner;
  logic [IDW-1:0] ptr;
  logic [7:0]     data_q;
  logic           last_q;
  logic           lock;
  logic [7:0]     last_id;

  logic [N-1:0]   mask;
  logic [IDW-1:0] pick_ptr;
  logic [N-1:0]   pick_oh;
  logic [IDW-1:0] sel;
  logic           pick_any;
  logic           take;
  logic           need_hdr;
  logic [7:0]     sel_data;
  logic [IDW-1:0] ptr_next;

  // While a packet is open only its owner is eligible.
  assign mask     = lock ? ({{(N-1){1'b0}}, 1'b1} << owner) : {N{1'b1}};
  assign pick_ptr = lock ? owner : ptr;

  rr_pick #(.N(N), .IDW(IDW)) u_pick (
    .req    (req_valid),
    .ptr    (pick_ptr),
    .mask   (mask),
    .onehot (pick_oh),
    .index  (sel),
    .any    (pick_any)
  );

  assign take      = !reset && (state == ST_IDLE) && !tx_busy && pick_any;
  assign req_ready = take ? pick_oh : '0;
  assign sel_data  = req_data[8*sel +: 8];
  assign need_hdr  = (HDR_EN != 0) && (8'(sel) != last_id);
  assign ptr_next  = (owner == IDW'(N-1)) ? '0 : owner + 1'b1;

  // Transmit strobe and data come from registered state only.
  assign tx_wr   = (state == ST_SEND_HDR) || (state == ST_SEND_DATA);
  assign tx_data = (state == ST_SEND_HDR)  ? (HDR_BASE | 8'(owner)) :
                   (state == ST_SEND_DATA) ? data_q : 8'h00;
  assign active  = (state != ST_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      owner   <= '0;
      ptr     <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      lock    <= 1'b0;
      last_id <= ID_NONE;
      grant   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (take) begin
            data_q <= sel_data;
            last_q <= req_last[sel];
            owner  <= sel;
            grant  <= pick_oh;
            state  <= need_hdr ? ST_SEND_HDR : ST_SEND_DATA;
          end
        end
        ST_SEND_HDR:  state <= ST_WAIT_HDR;
        ST_WAIT_HDR:  if (!tx_busy) state <= ST_SEND_DATA;
        ST_SEND_DATA: begin
          last_id <= 8'(owner);
          state   <= ST_WAIT_DATA;
        end
        ST_WAIT_DATA: begin
          if (!tx_busy) begin
            state <= ST_IDLE;
            if (last_q) begin
              lock  <= 1'b0;
              ptr   <= ptr_next;
              grant <= '0;
            end else begin
              lock  <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
